demux_1x4_4bit_buf: RTL and testbench
=====================================

# demux_1x4_4bit_buf

Buffered 1-to-4 demultiplexer for 4-bit words: routes one input word per clock to one of four output lanes chosen by `s1:s0`. Each lane holds the word in a single-entry register until its consumer acknowledges it. The block sits downstream of the 4-to-1 4-bit multiplexer path and splits a shared 4-bit bus back into four per-channel streams. Per-lane delivery counters support bring-up and lab checks.

## Interface
- `WIDTH`, 4, data width of input and every lane
- `CNT_W`, 8, width of each per-lane accepted-word counter
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: reset, synchronous, active-high
- `in_data` input WIDTH: word to route
- `in_valid` input 1: `in_data`, `s0`, `s1` are valid this cycle
- `in_ready` output 1: selected lane can take a word this cycle (combinational)
- `s0`, `s1` input 1 each: lane select, lane = {s1,s0}; 00→0, 01→1, 10→2, 11→3
- `out0`..`out3` output WIDTH each: lane holding registers
- `v0`..`v3` output 1 each: lane holds an unconsumed word
- `ack0`..`ack3` input 1 each: consumer takes the lane word this cycle
- `cnt0`..`cnt3` output CNT_W each: words accepted into the lane since reset

## Operation
- Lane states: EMPTY (`vN`=0) and FULL (`vN`=1); one 2-state FSM per lane.
- Selected lane L = {s1,s0}, evaluated every cycle.
- `in_ready` = !vL | ackL. Depends on `s0`, `s1`, `vL`, `ackL` only. Must not depend on `in_valid`.
- Accept = `in_valid` & `in_ready`. On accept: `outL` ← `in_data`, `vL` ← 1, `cntL` ← `cntL`+1.
- EMPTY→FULL on accept into the lane.
- FULL→EMPTY on `ackN` with no accept into the same lane.
- FULL→FULL with new data when `ackN` and accept happen in the same cycle (back-to-back pass-through, no bubble).
- `ackN` while `vN`=0 is ignored: no state, data or counter change.
- `in_valid` while lane L is FULL and `ackL`=0: word not taken, `in_ready`=0, lane unchanged. Upstream must hold the word and select until accepted.
- Non-selected lanes are never written. Their acks proceed independently in the same cycle.
- `outN` keeps its last value after ack. Data is meaningful only while `vN`=1.
- Counters wrap modulo 2^CNT_W (255→0), with no saturation and no flag.

## Timing
- Reset: all `outN`=0, `vN`=0, `cntN`=0. `in_ready`=1 in the cycle after reset, because every lane is EMPTY.
- `rst` asserted mid-operation overrides accept and ack in the same cycle. Held words are discarded.
- Latency: word accepted at edge N shows on `outL` with `vL`=1 immediately after edge N (one cycle).
- Throughput: one word per clock, provided the target lane is EMPTY or acked in the same cycle.
- Ack takes effect at the edge where it is sampled high. `vN` falls after that edge.
- `cntN` updates at the same edge as `vN`/`outN`.

## Test plan
- Reset then fill:
  - `rst` 1 cycle, then accept 1010 with s=00, 1111 with s=01, 0000 with s=10, 0101 with s=11 on consecutive cycles.
  - Required: `in_ready`=1 on all four cycles; out0..3 = 1010/1111/0000/0101; v0..3=1; cnt0..3=1.
- Backpressure:
  - Lane 0 FULL, s=00, `in_valid`=1 with 0011, no ack0.
  - Required: `in_ready`=0; out0 stays 1010; cnt0 stays 1.
  - Then assert ack0 for one cycle. Required: `in_ready`=1 that cycle; out0=0011 after the edge; v0 stays 1; cnt0=2.
- Ack on empty lane:
  - ack2 pulse while v2=0. Required: out2, v2, cnt2 unchanged.
  - ack1 on FULL lane 1 with `in_valid`=0. Required: v1=0 next cycle.
- Independent lanes:
  - Accept into lane 3 while ack0 and ack1 are high in the same cycle.
  - Required: v0=v1=0; v3=1 with new data; lanes 0 and 1 data unaffected.
- Counter wrap:
  - 256 accepts into lane 2, with ack2 held high throughout.
  - Required: `in_ready` stays 1; cnt2 goes 255→0; v2=1 after the final accept.
- Reset mid-operation:
  - All lanes FULL; assert `rst` together with `in_valid` and ack0.
  - Required: after the edge, all vN=0, outN=0, cntN=0, `in_ready`=1.

Source files
------------

// File: rtl/demux_1x4_4bit_buf.sv
// rtl/demux_1x4_4bit_buf.sv - buffered 1-to-4 demux with single-entry lane registers and per-lane counters

module demux_1x4_4bit_buf #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             ack0,
  input  logic             ack1,
  input  logic             ack2,
  input  logic             ack3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_state_t;

  lane_state_t      state_q [4];
  lane_state_t      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [3:0]       ack;
  logic [3:0]       valid;
  logic [3:0]       accept;
  logic [1:0]       sel;

  assign sel = {s1, s0};
  assign ack = {ack3, ack2, ack1, ack0};

  // per-lane state register; reset discards any held word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) state_q[i] <= EMPTY;
      else     state_q[i] <= state_d[i];
    end
  end

  // next state: a fresh accept keeps or makes the lane FULL, otherwise an ack drains it
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        EMPTY:   if (accept[i]) state_d[i] = FULL;
        FULL:    if (!accept[i] && ack[i]) state_d[i] = EMPTY;
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  // outputs: lane valids, ready for the selected lane, and one-hot accept strobes
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valid[i] = (state_q[i] == FULL);
    end
    // in_valid deliberately excluded so upstream can gate on ready without a loop
    in_ready = !valid[sel] || ack[sel];
    accept   = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = in_valid && in_ready && (sel == 2'(i));
    end
  end

  // lane data and delivery counters update only on accept; data is kept after ack
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end else if (accept[i]) begin
        data_q[i] <= in_data;
        cnt_q[i]  <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign out0 = data_q[0];
  assign out1 = data_q[1];
  assign out2 = data_q[2];
  assign out3 = data_q[3];
  assign v0   = valid[0];
  assign v1   = valid[1];
  assign v2   = valid[2];
  assign v3   = valid[3];
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_1x4_4bit_buf.sv
// tb/tb_demux_1x4_4bit_buf.sv - randomized and directed self-checking bench for demux_1x4_4bit_buf

module tb_demux_1x4_4bit_buf;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             s0 = 1'b0, s1 = 1'b0;
  logic             ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0, ack3 = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic             v0, v1, v2, v3;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  demux_1x4_4bit_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  logic [WIDTH-1:0] d_out [4];
  logic             d_v   [4];
  logic [CNT_W-1:0] d_cnt [4];
  assign d_out[0] = out0; assign d_out[1] = out1; assign d_out[2] = out2; assign d_out[3] = out3;
  assign d_v[0]   = v0;   assign d_v[1]   = v1;   assign d_v[2]   = v2;   assign d_v[3]   = v3;
  assign d_cnt[0] = cnt0; assign d_cnt[1] = cnt1; assign d_cnt[2] = cnt2; assign d_cnt[3] = cnt3;

  // reference model: what each lane holds, whether it is occupied, and how many words it took
  int m_out [4];
  bit m_v   [4];
  int m_cnt [4];
  bit m_init = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one clock: drive inputs, check ready mid-cycle, advance model at the edge, check lanes after
  task automatic cycle(input bit r, input bit val, input logic [3:0] d, input int lane, input logic [3:0] ak);
    bit exp_rdy;
    rst = r; in_valid = val; in_data = d;
    {s1, s0} = 2'(lane);
    {ack3, ack2, ack1, ack0} = ak;
    @(negedge clk);
    exp_rdy = !m_v[lane] || ak[lane];
    if (m_init) check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_out[i] = 0; m_v[i] = 1'b0; m_cnt[i] = 0;
      end
      m_init = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (ak[i]) m_v[i] = 1'b0;
      if (val && exp_rdy) begin
        m_out[lane] = int'(d);
        m_v[lane]   = 1'b1;
        m_cnt[lane] = (m_cnt[lane] + 1) % (1 << CNT_W);
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out%0d", i), 32'(d_out[i]), 32'(m_out[i]));
      check($sformatf("v%0d", i),   32'(d_v[i]),   32'(m_v[i]));
      check($sformatf("cnt%0d", i), 32'(d_cnt[i]), 32'(m_cnt[i]));
    end
  endtask

  int start_cnt2;

  initial begin
    // reset, then idle inputs show ready with every lane empty
    cycle(1, 0, 4'h0, 0, 4'b0000);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(in_ready), 32'd1);

    // fill all four lanes on consecutive cycles
    cycle(0, 1, 4'b1010, 0, 4'b0000);
    cycle(0, 1, 4'b1111, 1, 4'b0000);
    cycle(0, 1, 4'b0000, 2, 4'b0000);
    cycle(0, 1, 4'b0101, 3, 4'b0000);
    check("fill_out0", 32'(out0), 32'hA);
    check("fill_out1", 32'(out1), 32'hF);
    check("fill_out3", 32'(out3), 32'h5);
    check("fill_cnt3", 32'(cnt3), 32'd1);

    // backpressure, then ack releases the slot with no bubble
    cycle(0, 1, 4'b0011, 0, 4'b0000);
    check("bp_out0", 32'(out0), 32'hA);
    check("bp_cnt0", 32'(cnt0), 32'd1);
    cycle(0, 1, 4'b0011, 0, 4'b0001);
    check("pass_out0", 32'(out0), 32'h3);
    check("pass_v0", 32'(v0), 32'd1);
    check("pass_cnt0", 32'(cnt0), 32'd2);

    // drain lane 2, then ack it again while empty; ack lane 1 with no input
    cycle(0, 0, 4'h0, 2, 4'b0100);
    cycle(0, 0, 4'h0, 2, 4'b0100);
    check("ack_empty_cnt2", 32'(cnt2), 32'd1);
    cycle(0, 0, 4'h0, 1, 4'b0010);
    check("ack1_v1", 32'(v1), 32'd0);

    // refill lane 1, then accept into lane 3 while lanes 0, 1 and 3 are acked
    cycle(0, 1, 4'b1100, 1, 4'b0000);
    cycle(0, 1, 4'b0110, 3, 4'b1011);
    check("ind_v0", 32'(v0), 32'd0);
    check("ind_v1", 32'(v1), 32'd0);
    check("ind_out3", 32'(out3), 32'h6);
    check("ind_out1", 32'(out1), 32'hC);

    // 256 back-to-back accepts into lane 2 wrap its counter to the start value
    start_cnt2 = int'(cnt2);
    for (int k = 0; k < 256; k++) cycle(0, 1, 4'($urandom), 2, 4'b0100);
    check("wrap_cnt2", 32'(cnt2), 32'(start_cnt2));
    check("wrap_v2", 32'(v2), 32'd1);

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++)
      cycle(($urandom_range(63) == 0), $urandom_range(1), 4'($urandom), int'($urandom_range(3)), 4'($urandom));

    // fill everything, then reset together with a valid word and ack0
    for (int i = 0; i < 4; i++) cycle(0, 1, 4'($urandom), i, 4'(1 << i));
    cycle(0, 0, 4'h0, 0, 4'b0000);
    check("pre_rst_v3", 32'(v3), 32'd1);
    cycle(1, 1, 4'hF, 0, 4'b0001);
    rst = 1'b0; in_valid = 1'b0; ack0 = 1'b0;
    #1;
    check("mid_rst_v", 32'({v3, v2, v1, v0}), 32'd0);
    check("mid_rst_out", 32'({out3, out2, out1, out0}), 32'd0);
    check("mid_rst_cnt", 32'(cnt0 | cnt1 | cnt2 | cnt3), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
